// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode + extension words over PMRD/PMIE, issues them on COMM/DMI.
// Latency: 3 cycles from PMRD to COMME for a one-word instruction with 1-cycle memory.
// Backpressure: HOLD freezes the issue states; fetch states ignore HOLD. JMP overrides everything.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] PMA,
    output logic        PMRD,
    input  logic [15:0] PMI,
    input  logic        PMIE,
    input  logic        JMP,
    input  logic [15:0] JADDR,
    input  logic        HOLD,
    output logic [15:0] COMM,
    output logic        COMME,
    output logic [15:0] DMI,
    output logic        DMIE,
    output logic [15:0] PC
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_X1,
        FETCH_X2,
        ISSUE1,
        ISSUE2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic        pend;       // a request is outstanding
    logic        drop;       // outstanding response belongs to a redirected stream
    logic [15:0] instr;
    logic [15:0] ext_src;    // also holds the single format-2 extension
    logic [15:0] ext_dst;
    logic        fmt1;
    logic        src_vld;
    logic        dst_vld;
    logic [15:0] ipc;

    logic        acc;
    logic        take;
    logic        req;
    logic        ld_op;
    logic        ld_src;
    logic        ld_dst;
    logic        dec_fmt1;
    logic        dec_src;
    logic        dec_dst;

    // Length decode of the first word as it arrives on PMI
    always_comb begin
        dec_fmt1 = (PMI[15:12] >= 4'h4);
        dec_src  = dec_fmt1 ? PMI[4] : ((PMI[15:12] == 4'h1) && (PMI[5:4] == 2'b01));
        dec_dst  = dec_fmt1 && PMI[7];
    end

    always_comb begin
        state_nxt = state;
        ld_op     = 1'b0;
        ld_src    = 1'b0;
        ld_dst    = 1'b0;
        acc       = pend && PMIE;
        take      = acc && !drop && !JMP;

        case (state)
            FETCH_OP: begin
                if (take) begin
                    ld_op     = 1'b1;
                    state_nxt = (dec_src || dec_dst) ? FETCH_X1 : ISSUE1;
                end
            end
            FETCH_X1: begin
                if (take) begin
                    if (src_vld) begin
                        ld_src    = 1'b1;
                        state_nxt = dst_vld ? FETCH_X2 : ISSUE1;
                    end else begin
                        ld_dst    = 1'b1;
                        state_nxt = ISSUE1;
                    end
                end
            end
            FETCH_X2: begin
                if (take) begin
                    ld_dst    = 1'b1;
                    state_nxt = ISSUE1;
                end
            end
            ISSUE1: begin
                if (!HOLD) state_nxt = fmt1 ? ISSUE2 : FETCH_OP;
            end
            ISSUE2: begin
                if (!HOLD) state_nxt = FETCH_OP;
            end
            default: state_nxt = FETCH_OP;
        endcase

        if (JMP) state_nxt = FETCH_OP;

        pc_nxt = JMP ? (JADDR & 16'hFFFE) : (take ? pc + PC_STEP : pc);

        // New request only once the bus is free; a retiring response frees it this cycle
        req = ((state_nxt == FETCH_OP) || (state_nxt == FETCH_X1) || (state_nxt == FETCH_X2))
              && (!pend || acc);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= FETCH_OP;
            pc      <= RESET_PC;
            pend    <= 1'b0;
            drop    <= 1'b0;
            PMRD    <= 1'b0;
            PMA     <= 16'h0000;
            instr   <= 16'h0000;
            ext_src <= 16'h0000;
            ext_dst <= 16'h0000;
            fmt1    <= 1'b0;
            src_vld <= 1'b0;
            dst_vld <= 1'b0;
            ipc     <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            PMRD  <= req;
            if (req) PMA <= pc_nxt;
            pend  <= req || (pend && !acc);
            drop  <= !acc && (drop || (JMP && pend));
            if (ld_op) begin
                instr   <= PMI;
                ipc     <= pc;
                fmt1    <= dec_fmt1;
                src_vld <= dec_src;
                dst_vld <= dec_dst;
            end
            if (ld_src) ext_src <= PMI;
            if (ld_dst) ext_dst <= PMI;
        end
    end

    // Issue outputs decode straight from state so a reset or redirect drops them at once
    always_comb begin
        COMME = (state == ISSUE1) || (state == ISSUE2);
        COMM  = COMME ? instr : 16'h0000;
        DMIE  = 1'b0;
        DMI   = 16'h0000;
        if (state == ISSUE1 && src_vld) begin
            DMIE = 1'b1;
            DMI  = ext_src;
        end else if (state == ISSUE2 && dst_vld) begin
            DMIE = 1'b1;
            DMI  = ext_dst;
        end
        PC = ipc;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the CPU core.
- Reads instruction words and their extension words from program memory through a request/valid handshake.
- Decodes the instruction length from the first word.
- Presents each instruction to the core on COMM/COMME, and its extension words on DMI/DMIE, with the per-cycle timing the core's two-phase operand read requires.

Parameters:
- RESET_PC, 16'h0000, program address loaded on reset.
- PC_STEP, 2, address increment per fetched word (byte addressing).

Ports:
- CLK  in  1  core clock (same clock as the core's F1).
- RST_N  in  1  asynchronous active-low reset.
- PMA  out  16  program memory read address.
- PMRD  out  1  read request; one-cycle pulse per word.
- PMI  in  16  program memory read data.
- PMIE  in  1  PMI valid; arrives 1..N cycles after PMRD.
- JMP  in  1  redirect request, one-cycle pulse.
- JADDR  in  16  redirect target address.
- HOLD  in  1  core stall; freezes the issue outputs.
- COMM  out  16  instruction word to the core.
- COMME  out  1  COMM valid.
- DMI  out  16  extension word for the current issue cycle.
- DMIE  out  1  DMI valid.
- PC  out  16  address of the instruction currently issued.

Behaviour:
- Reset (async, RST_N=0):
  - State=FETCH_OP; internal pc=RESET_PC.
  - PMRD=0, PMA=0, COMM=0, COMME=0, DMI=0, DMIE=0, PC=RESET_PC.
  - Any outstanding memory response is forgotten.
  - A PMIE arriving in the first cycle after reset release is ignored unless PMRD was issued after reset.
- Memory handshake:
  - PMRD is high for exactly one cycle with PMA=pc.
  - There is at most one outstanding request.
  - The unit waits in the current state until PMIE=1, then latches PMI and advances pc by PC_STEP (mod 2^16, wraps 16'hFFFE->16'h0000).
- Length decode, from the first word W:
  - W[15:12]>=4'h4 (format 1): ext_src needed if W[5:4] is 01 or 11; ext_dst needed if W[7]=1.
  - W[15:12]==4'h1 (format 2): one extension if W[5:4]==01; otherwise none.
  - W[15:12] is 4'h0, 4'h2 or 4'h3: no extension.
- States:
  - FETCH_OP: request the first word. On PMIE go to FETCH_X1 if any extension is needed, else to ISSUE1.
  - FETCH_X1: fetch the first needed extension. That is ext_src for format 1 if needed, otherwise ext_dst, or the format-2 extension. Go to FETCH_X2 if format 1 needs both extensions, else ISSUE1.
  - FETCH_X2: fetch ext_dst. Then go to ISSUE1.
  - ISSUE1: COMME=1, COMM=W, PC=address of W. DMI=ext_src, or the format-2 extension; DMIE=1 if that word exists, else DMI=0 and DMIE=0. Format 1 goes to ISSUE2; all other formats go to FETCH_OP.
  - ISSUE2 (format 1 only): COMME=1, COMM=W held. DMI=ext_dst with DMIE=1 if it exists, else DMI=0 and DMIE=0. Go to FETCH_OP.
- Issue timing:
  - Format 1 is presented for exactly two consecutive enabled cycles: source phase, then destination phase.
  - Format 2 and jumps are presented for exactly one cycle.
  - COMME=0 in every FETCH_* state. There is no prefetch overlap.
- HOLD:
  - When HOLD=1 in ISSUE1 or ISSUE2, state and all outputs are frozen, COMME stays high.
  - HOLD has no effect in FETCH_* states; fetching continues.
- JMP (priority over HOLD and all state transitions):
  - On the sampled cycle, pc<=JADDR, COMME<=0, DMIE<=0, and next state is FETCH_OP.
  - If a request is outstanding, its PMIE is awaited and its data dropped. Only then is the new PMRD issued.
  - JMP while idle-waiting issues PMRD for JADDR the following cycle.
  - JMP in the same cycle as PMIE: the data is dropped.
  - JADDR[0] is ignored; it is forced to 0.
- Latency with one-cycle memory: one-word instruction fetch to COMME takes 3 cycles (PMRD, PMIE, issue).

Test Plan:
- Reset, memory[0]=16'h1004 (format 2, As=00), 1-cycle memory:
  - PMRD at addr 0.
  - Then COMME=1 for one cycle with COMM=16'h1004, DMIE=0, PC=0.
  - Next PMRD at addr 2.
- memory[2..6]=16'h4593, 16'h0005, 16'h000A (format 1, As=01, Ad=1):
  - Three PMRDs at 2, 4, 6.
  - ISSUE1: COMM=16'h4593, DMI=16'h0005, DMIE=1.
  - ISSUE2: same COMM, DMI=16'h000A.
  - Then fetch at 8.
- Format 1 16'h4403 (As=00, Ad=0): two issue cycles, both with DMIE=0 and DMI=0.
- HOLD=1 for 3 cycles during ISSUE1 of a format-1 instruction: COMM/DMI frozen, then ISSUE2 proceeds normally. Total COMME-high cycles = 5.
- Memory latency 4 cycles; JMP with JADDR=16'h0101 while a request is outstanding:
  - Old PMIE data is never issued.
  - Next PMRD has PMA=16'h0100.
  - The issued PC is 16'h0100.
- Fetch at pc=16'hFFFE: next PMA is 16'h0000 (wrap). RST_N pulse mid-ISSUE2: COMME drops asynchronously and PMRD restarts at RESET_PC.
